// File: rtl/prime_bus_pkg.sv
// prime_bus_pkg: shared constants and types for the prime-finder bus master.
//   - default register map (A = argument, W = result, S = status)
//   - status code reported by the slave while it is searching for primes
//   - master sequencing states, read-target selector, access-engine phases
package prime_bus_pkg;

   localparam logic [15:0] ADDR_A_DEF      = 16'hD4;
   localparam logic [15:0] ADDR_W_DEF      = 16'hE4;
   localparam logic [15:0] ADDR_S_DEF      = 16'hEC;
   localparam logic [31:0] STATUS_BUSY_DEF = 32'hCC;

   // Width of the status-poll counter; it saturates at all-ones.
   localparam int POLL_CNT_W = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_SETUP,
      ST_WR_STB,
      ST_WR_HOLD,
      ST_WAIT,
      ST_RD_SETUP,
      ST_RD_STB,
      ST_RD_HOLD,
      ST_EVAL,
      ST_RESP
   } state_e;

   typedef enum logic {
      TGT_S,
      TGT_W
   } rd_target_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_STB,
      PH_HOLD
   } xfer_ph_e;

endpackage

// File: rtl/prime_bus_xfer.sv
// prime_bus_xfer: single register access engine (SETUP / STROBE / HOLD).
//   clk, n_reset       : clock, async active-low reset
//   start, rnw         : launch an access (honoured only when idle); 1 = read
//   addr, wdata        : access address and write data, latched on start
//   done               : high during the HOLD cycle
//   rdata              : read data, captured on the edge that ends HOLD
//   saddress, srd, swr, sdata_in, sdata_out : slave bus
// Address and write data are registered on start, so they only change on
// entry to SETUP; strobes are registered so each is exactly one cycle wide.
module prime_bus_xfer
   import prime_bus_pkg::*;
(
   input  logic        clk,
   input  logic        n_reset,
   input  logic        start,
   input  logic        rnw,
   input  logic [15:0] addr,
   input  logic [31:0] wdata,
   output logic        done,
   output logic [31:0] rdata,
   output logic [15:0] saddress,
   output logic        srd,
   output logic        swr,
   output logic [31:0] sdata_in,
   input  logic [31:0] sdata_out
);

   xfer_ph_e    ph_q, ph_d;
   logic        rnw_q, rnw_d;
   logic        srd_q, srd_d;
   logic        swr_q, swr_d;
   logic [15:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         ph_q    <= PH_IDLE;
         rnw_q   <= 1'b0;
         srd_q   <= 1'b0;
         swr_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         ph_q    <= ph_d;
         rnw_q   <= rnw_d;
         srd_q   <= srd_d;
         swr_q   <= swr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      ph_d    = ph_q;
      rnw_d   = rnw_q;
      srd_d   = 1'b0;
      swr_d   = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (ph_q)
         PH_IDLE: begin
            if (start) begin
               ph_d   = PH_SETUP;
               rnw_d  = rnw;
               addr_d = addr;
               // reads leave the last write data on the bus
               if (!rnw) wdata_d = wdata;
            end
         end
         PH_SETUP: begin
            ph_d  = PH_STB;
            srd_d = rnw_q;
            swr_d = !rnw_q;
         end
         PH_STB: begin
            ph_d = PH_HOLD;
         end
         PH_HOLD: begin
            ph_d = PH_IDLE;
            if (rnw_q) rdata_d = sdata_out;
         end
         default: ph_d = PH_IDLE;
      endcase
   end

   assign done     = (ph_q == PH_HOLD);
   assign rdata    = rdata_q;
   assign saddress = addr_q;
   assign srd      = srd_q;
   assign swr      = swr_q;
   assign sdata_in = wdata_q;

endmodule

// File: rtl/prime_bus_master.sv
// prime_bus_master: bus initiator for the prime-finder slave.
// Takes N on the command port, writes it to register A, polls status S every
// POLL_GAP idle cycles until the search is over, reads result W and offers it
// on the response port.
//   clk, n_reset                  : clock, async active-low reset
//   cmd_valid, cmd_ready, cmd_n   : command handshake and prime index
//   rsp_valid, rsp_ready, rsp_data: response handshake and W value
//   rsp_err                       : timeout flag (PRIME_BUS_MASTER_TIMEOUT_EN)
//   busy                          : any state other than IDLE
//   saddress, srd, swr, sdata_in, sdata_out : slave bus
// Build option PRIME_BUS_MASTER_TIMEOUT_EN: adds MAX_POLLS and rsp_err; a job
// whose status is still busy after MAX_POLLS polls ends with data all-ones and
// rsp_err set, without reading W.
module prime_bus_master
   import prime_bus_pkg::*;
#(
   parameter logic [15:0] ADDR_A      = ADDR_A_DEF,
   parameter logic [15:0] ADDR_W      = ADDR_W_DEF,
   parameter logic [15:0] ADDR_S      = ADDR_S_DEF,
   parameter logic [31:0] STATUS_BUSY = STATUS_BUSY_DEF,
   parameter int          POLL_GAP    = 16,
   parameter int          START_POLLS = 4
`ifdef PRIME_BUS_MASTER_TIMEOUT_EN
   ,parameter int         MAX_POLLS   = 65535
`endif
)(
   input  logic        clk,
   input  logic        n_reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_n,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
`ifdef PRIME_BUS_MASTER_TIMEOUT_EN
   output logic        rsp_err,
`endif
   output logic        busy,
   output logic [15:0] saddress,
   output logic        srd,
   output logic        swr,
   output logic [31:0] sdata_in,
   input  logic [31:0] sdata_out
);

   localparam int                    GAP_W     = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(POLL_GAP - 1);
   localparam logic [POLL_CNT_W-1:0] START_LIM = POLL_CNT_W'(START_POLLS);
`ifdef PRIME_BUS_MASTER_TIMEOUT_EN
   localparam logic [POLL_CNT_W-1:0] MAX_LIM   = POLL_CNT_W'(MAX_POLLS);
`endif

   state_e                 state_q, state_d;
   rd_target_e             tgt_q, tgt_d;
   logic [GAP_W-1:0]       gap_q, gap_d;
   logic [POLL_CNT_W-1:0]  poll_q, poll_d, poll_inc;
   logic                   seen_q, seen_d;
   logic [31:0]            rsp_data_q, rsp_data_d;
`ifdef PRIME_BUS_MASTER_TIMEOUT_EN
   logic                   err_q, err_d;
`endif

   logic        x_start, x_rnw, x_done;
   logic [15:0] x_addr;
   logic [31:0] x_wdata, x_rdata;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q    <= ST_IDLE;
         tgt_q      <= TGT_S;
         gap_q      <= '0;
         poll_q     <= '0;
         seen_q     <= 1'b0;
         rsp_data_q <= '0;
`ifdef PRIME_BUS_MASTER_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         gap_q      <= gap_d;
         poll_q     <= poll_d;
         seen_q     <= seen_d;
         rsp_data_q <= rsp_data_d;
`ifdef PRIME_BUS_MASTER_TIMEOUT_EN
         err_q      <= err_d;
`endif
      end
   end

   assign poll_inc = (&poll_q) ? poll_q : poll_q + 1'b1;

   // Every transition into a *_SETUP state launches the access engine in the
   // same cycle, so the engine's SETUP phase lines up with the master state.
   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      gap_d      = gap_q;
      poll_d     = poll_q;
      seen_d     = seen_q;
      rsp_data_d = rsp_data_q;
`ifdef PRIME_BUS_MASTER_TIMEOUT_EN
      err_d      = err_q;
`endif
      x_start    = 1'b0;
      x_rnw      = 1'b0;
      x_addr     = '0;
      x_wdata    = '0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               x_start = 1'b1;
               x_addr  = ADDR_A;
               x_wdata = cmd_n;
               seen_d  = 1'b0;
               poll_d  = '0;
               state_d = ST_WR_SETUP;
            end
         end
         ST_WR_SETUP: state_d = ST_WR_STB;
         ST_WR_STB:   state_d = ST_WR_HOLD;
         ST_WR_HOLD: begin
            if (x_done) begin
               gap_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (gap_q == GAP_LAST) begin
               x_start = 1'b1;
               x_rnw   = 1'b1;
               x_addr  = ADDR_S;
               tgt_d   = TGT_S;
               state_d = ST_RD_SETUP;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         ST_RD_SETUP: state_d = ST_RD_STB;
         ST_RD_STB:   state_d = ST_RD_HOLD;
         ST_RD_HOLD:  if (x_done) state_d = ST_EVAL;
         ST_EVAL: begin
            if (tgt_q == TGT_W) begin
               rsp_data_d = x_rdata;
               state_d    = ST_RESP;
            end else if (x_rdata == STATUS_BUSY) begin
               seen_d = 1'b1;
               poll_d = poll_inc;
`ifdef PRIME_BUS_MASTER_TIMEOUT_EN
               if (poll_inc >= MAX_LIM) begin
                  rsp_data_d = '1;
                  err_d      = 1'b1;
                  state_d    = ST_RESP;
               end else
`endif
               begin
                  gap_d   = '0;
                  state_d = ST_WAIT;
               end
            end else if (seen_q || (poll_inc >= START_LIM)) begin
               // Search observed to finish, or it never showed busy within
               // START_POLLS polls and must already have been done.
               if (!seen_q) poll_d = poll_inc;
               x_start = 1'b1;
               x_rnw   = 1'b1;
               x_addr  = ADDR_W;
               tgt_d   = TGT_W;
               state_d = ST_RD_SETUP;
            end else begin
               poll_d  = poll_inc;
               gap_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
`ifdef PRIME_BUS_MASTER_TIMEOUT_EN
               err_d = 1'b0;
`endif
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   prime_bus_xfer u_xfer (
      .clk      (clk),
      .n_reset  (n_reset),
      .start    (x_start),
      .rnw      (x_rnw),
      .addr     (x_addr),
      .wdata    (x_wdata),
      .done     (x_done),
      .rdata    (x_rdata),
      .saddress (saddress),
      .srd      (srd),
      .swr      (swr),
      .sdata_in (sdata_in),
      .sdata_out(sdata_out)
   );

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_data  = rsp_data_q;
`ifdef PRIME_BUS_MASTER_TIMEOUT_EN
   assign rsp_err   = err_q;
`endif

endmodule
